// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM states and
// small opcode classification helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } alu_issue_state_t;

    // Opcodes the ALU implements; anything above mod is rejected
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_MOD);
    endfunction

    // Operations that take the multicycle path through the ALU
    function automatic logic op_is_long(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

    // Operations whose second operand must be non-zero
    function automatic logic op_needs_divisor(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the shared ALU: accepts one request at a time,
// drives the ALU operand/operation registers, waits for the result to
// settle, captures it and returns it with the request tag.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 4,
    parameter int MULDIV_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] alu_reg1,
    output logic [DATA_W-1:0] alu_reg2,
    output logic [3:0]        alu_operation,
    input  logic [DATA_W-1:0] alu_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [TAG_W-1:0]  resp_tag
);

    // Counter preload: WAIT is entered after EXEC, so one settle cycle is
    // already spent by the time the counter starts counting down.
    localparam logic [3:0] WAIT_LOAD = (MULDIV_WAIT > 0) ? 4'(MULDIV_WAIT - 1) : 4'd0;

    alu_issue_state_t state;
    alu_issue_state_t state_next;
    logic [3:0]       cnt;
    logic [3:0]       cnt_next;
    logic             accept_legal;
    logic             accept_err;
    logic             capture;
    logic             req_bad;

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    // Rejected requests: unknown opcode, or div/mod with a zero divisor
    assign req_bad = !op_is_legal(req_op) ||
                     (op_needs_divisor(req_op) && (req_b == '0));

    // Next-state logic plus the load strobes for the datapath registers
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        accept_legal = 1'b0;
        accept_err   = 1'b0;
        capture      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        accept_err = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        accept_legal = 1'b1;
                        state_next   = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (op_is_long(alu_operation) && (MULDIV_WAIT != 0)) begin
                    cnt_next   = WAIT_LOAD;
                    state_next = ST_WAIT;
                end else begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and settle counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // ALU port registers only move on a legal accept so the ALU stays quiet
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_reg1      <= '0;
            alu_reg2      <= '0;
            alu_operation <= 4'd0;
        end else if (accept_legal) begin
            alu_reg1      <= req_a;
            alu_reg2      <= req_b;
            alu_operation <= req_op;
        end
    end

    // Response registers: tag at accept, data/err at capture or rejection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
            resp_tag  <= '0;
        end else begin
            if (accept_legal || accept_err) begin
                resp_tag <= req_tag;
            end
            if (accept_err) begin
                resp_data <= '0;
                resp_err  <= 1'b1;
            end else if (capture) begin
                resp_data <= alu_out;
                resp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with a behavioural ALU beside it.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DATA_W      = 32;
    localparam int TAG_W       = 4;
    localparam int MULDIV_WAIT = 2;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] alu_reg1;
    logic [DATA_W-1:0] alu_reg2;
    logic [3:0]        alu_operation;
    logic [DATA_W-1:0] alu_out;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic [TAG_W-1:0]  resp_tag;

    int checkCount;
    int errorCount;

    alu_issue_ctrl #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .MULDIV_WAIT(MULDIV_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_operation(alu_operation),
        .alu_out(alu_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .resp_tag(resp_tag)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU driven by the controller's registered ports
    always_comb begin
        alu_out = '0;
        case (alu_operation)
            OP_ADD: alu_out = alu_reg1 + alu_reg2;
            OP_SUB: alu_out = alu_reg1 - alu_reg2;
            OP_MUL: alu_out = alu_reg1 * alu_reg2;
            OP_DIV: alu_out = (alu_reg2 != 0) ? alu_reg1 / alu_reg2 : '0;
            OP_MOD: alu_out = (alu_reg2 != 0) ? alu_reg1 % alu_reg2 : '0;
            default: alu_out = '0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and let it be accepted at the next edge
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] tag);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Count edges after the accept until resp_valid shows, bounded
    task automatic waitResponse(output int cycles);
        cycles = 0;
        while (!resp_valid && cycles < 50) begin
            tick();
            cycles++;
        end
    endtask

    // Full transaction with resp_ready high, checking latency and payload
    task automatic runOp(input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input int expLat,
                         input logic [31:0] expData, input logic expErr);
        int lat;
        applyStimulus(op, a, b, tag);
        checkOutput({name, "_ready_low"}, 32'(req_ready), 32'd0);
        waitResponse(lat);
        checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, "_data"}, resp_data, expData);
        checkOutput({name, "_err"}, 32'(resp_err), 32'(expErr));
        checkOutput({name, "_tag"}, 32'(resp_tag), 32'(tag));
        tick();
        checkOutput({name, "_ready_after"}, 32'(req_ready), 32'd1);
        checkOutput({name, "_valid_after"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] heldData;
        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 4'd0;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
        checkOutput("rst_resp_tag", 32'(resp_tag), 32'd0);
        checkOutput("rst_alu_reg1", alu_reg1, 32'd0);
        checkOutput("rst_alu_op", 32'(alu_operation), 32'd0);

        $display("[TB] add with wrap-around");
        applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd2, 4'd3);
        checkOutput("add_alu_op", 32'(alu_operation), 32'(OP_ADD));
        checkOutput("add_alu_reg1", alu_reg1, 32'hFFFF_FFFF);
        checkOutput("add_alu_reg2", alu_reg2, 32'd2);
        waitResponse(lat);
        checkOutput("add_latency", 32'(lat), 32'd1);
        checkOutput("add_data", resp_data, 32'h0000_0001);
        checkOutput("add_err", 32'(resp_err), 32'd0);
        checkOutput("add_tag", 32'(resp_tag), 32'd3);
        tick();
        checkOutput("add_ready_after", 32'(req_ready), 32'd1);

        $display("[TB] sub, div, mod");
        runOp("sub", OP_SUB, 32'd0, 32'd1, 4'd5, 1, 32'hFFFF_FFFF, 1'b0);
        runOp("div", OP_DIV, 32'd100, 32'd7, 4'd1, 1 + MULDIV_WAIT, 32'd14, 1'b0);
        runOp("mod", OP_MOD, 32'd100, 32'd7, 4'd2, 1 + MULDIV_WAIT, 32'd2, 1'b0);

        $display("[TB] rejected requests");
        runOp("divzero", OP_DIV, 32'd5, 32'd0, 4'd9, 0, 32'd0, 1'b1);
        checkOutput("divzero_reg2_kept", alu_reg2, 32'd7);
        checkOutput("divzero_reg1_kept", alu_reg1, 32'd100);
        runOp("illegal", 4'b1010, 32'd8, 32'd8, 4'd6, 0, 32'd0, 1'b1);
        checkOutput("illegal_op_kept", 32'(alu_operation), 32'(OP_MOD));

        $display("[TB] backpressure on mul");
        resp_ready = 1'b0;
        applyStimulus(OP_MUL, 32'h0001_0000, 32'h0001_0000, 4'd12);
        waitResponse(lat);
        checkOutput("bp_latency", 32'(lat), 32'(1 + MULDIV_WAIT));
        checkOutput("bp_data", resp_data, 32'd0);
        checkOutput("bp_err", 32'(resp_err), 32'd0);
        heldData = resp_data;
        for (int i = 0; i < 5; i++) begin
            req_op    = OP_ADD;
            req_a     = 32'd1;
            req_b     = 32'd1;
            req_tag   = 4'd15;
            req_valid = (i % 2 == 0);
            tick();
            checkOutput("bp_valid_held", 32'(resp_valid), 32'd1);
            checkOutput("bp_ready_low", 32'(req_ready), 32'd0);
            checkOutput("bp_data_held", resp_data, heldData);
            checkOutput("bp_tag_held", 32'(resp_tag), 32'd12);
            checkOutput("bp_reg1_held", alu_reg1, 32'h0001_0000);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        checkOutput("bp_ready_after", 32'(req_ready), 32'd1);
        checkOutput("bp_valid_after", 32'(resp_valid), 32'd0);

        $display("[TB] reset during WAIT");
        applyStimulus(OP_MUL, 32'd3, 32'd4, 4'd7);
        tick();
        checkOutput("mid_in_wait_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        checkOutput("mid_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("mid_req_ready", 32'(req_ready), 32'd1);
        checkOutput("mid_alu_reg1", alu_reg1, 32'd0);
        checkOutput("mid_alu_reg2", alu_reg2, 32'd0);
        checkOutput("mid_alu_op", 32'(alu_operation), 32'd0);
        checkOutput("mid_resp_tag", 32'(resp_tag), 32'd0);
        rst_n = 1'b1;
        tick();
        runOp("post_rst_mul", OP_MUL, 32'd3, 32'd4, 4'd8, 1 + MULDIV_WAIT, 32'd12, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
